// File: rtl/stc_pkg.sv
// Shared types and helpers for the sparse tensor-core A-side blocks.
package stc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Column index width; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stc_prio_pick.sv
// Combinational selector: indices of the lowest N_PE set bits of a mask,
// packed in ascending order from lane 0.
module stc_prio_pick
  import stc_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned N_PE  = 4,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]          mask,
  output logic [N_PE*IDX_W-1:0] idx,
  output logic [N_PE-1:0]       vld
);

  logic [N-1:0] work;
  logic         found;

  // Each lane takes the lowest bit still set, then removes it for later lanes.
  always_comb begin
    work  = mask;
    found = 1'b0;
    idx   = '0;
    vld   = '0;
    for (int l = 0; l < int'(N_PE); l++) begin
      found = 1'b0;
      for (int c = 0; c < int'(N); c++) begin
        if (!found && work[c]) begin
          idx[l*IDX_W +: IDX_W] = IDX_W'(c);
          vld[l]                = 1'b1;
          found                 = 1'b1;
          work[c]               = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/stc_a_nz_sched.sv
// Dense A-row to nonzero-beat scheduler: streams up to N_PE nonzeros per beat
// with their column indices, lowest columns first.
module stc_a_nz_sched
  import stc_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned DW_DATA = 16,
  parameter int unsigned N_PE    = 4,
  parameter int unsigned IDX_W   = idx_w(N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DW_DATA-1:0]      in_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_PE*DW_DATA-1:0]   out_a,
  output logic [N_PE*IDX_W-1:0]     out_idx,
  output logic [N_PE-1:0]           out_mask,
  output logic                      out_last
);

  state_t                 state, state_nxt;
  logic [N*DW_DATA-1:0]   row, row_nxt;
  logic [N-1:0]           rem, rem_nxt;
  logic [N-1:0]           nz;
  logic [N-1:0]           picked;
  logic [N-1:0]           left;
  logic [N_PE*IDX_W-1:0]  pick_idx;
  logic [N_PE-1:0]        pick_vld;
  logic                   last_c;
  logic                   active;
  logic                   load;

  stc_prio_pick #(
    .N     (N),
    .N_PE  (N_PE),
    .IDX_W (IDX_W)
  ) u_pick (
    .mask (rem),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  // Any set bit makes an element nonzero, including a lone sign bit.
  always_comb begin
    nz = '0;
    for (int c = 0; c < int'(N); c++) begin
      nz[c] = |in_row[c*DW_DATA +: DW_DATA];
    end
  end

  // Columns presented this beat; the beat is last when nothing is left after it.
  always_comb begin
    picked = '0;
    for (int l = 0; l < int'(N_PE); l++) begin
      if (pick_vld[l]) begin
        picked[pick_idx[l*IDX_W +: IDX_W]] = 1'b1;
      end
    end
    left   = rem & ~picked;
    last_c = (left == '0);
  end

  always_comb begin
    active   = (state == EMIT) && !reset;
    in_ready = !reset && ((state == IDLE) || (out_ready && last_c));
  end

  always_comb begin
    out_valid = active;
    out_last  = active && last_c;
    out_mask  = active ? pick_vld : '0;
    out_idx   = '0;
    out_a     = '0;
    for (int l = 0; l < int'(N_PE); l++) begin
      if (active && pick_vld[l]) begin
        out_idx[l*IDX_W +: IDX_W] = pick_idx[l*IDX_W +: IDX_W];
        for (int c = 0; c < int'(N); c++) begin
          if (pick_idx[l*IDX_W +: IDX_W] == IDX_W'(c)) begin
            out_a[l*DW_DATA +: DW_DATA] = row[c*DW_DATA +: DW_DATA];
          end
        end
      end
    end
  end

  // Next-state: a new row may load in IDLE or on the cycle the last beat leaves.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    rem_nxt   = rem;
    load      = in_valid && in_ready;
    case (state)
      IDLE: begin
      end
      EMIT: begin
        if (out_ready) begin
          rem_nxt = left;
          if (last_c) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      row_nxt   = in_row;
      rem_nxt   = nz;
      state_nxt = EMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      row   <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      rem   <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_stc_a_nz_sched.sv
// Scoreboard bench for stc_a_nz_sched at N=16, N_PE=4, DW_DATA=16.
module tb_stc_a_nz_sched;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_row;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_a;
  logic [15:0]  out_idx;
  logic [3:0]   out_mask;
  logic         out_last;

  typedef struct packed {
    logic [63:0] a;
    logic [15:0] idx;
    logic [3:0]  mask;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  stc_a_nz_sched #(
    .N       (16),
    .DW_DATA (16),
    .N_PE    (4),
    .IDX_W   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_idx   (out_idx),
    .out_mask  (out_mask),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: gather nonzero columns, split into groups of four lanes.
  function automatic void push_model(input logic [255:0] row);
    int    cols[$];
    int    nb;
    int    j;
    beat_t b;
    logic [15:0] v;
    for (int c = 0; c < 16; c++) begin
      v = row[c*16 +: 16];
      if (v != 16'h0) cols.push_back(c);
    end
    nb = (cols.size() == 0) ? 1 : (cols.size() + 3) / 4;
    for (int k = 0; k < nb; k++) begin
      b = '0;
      for (int l = 0; l < 4; l++) begin
        j = k * 4 + l;
        if (j < cols.size()) begin
          b.a[l*16 +: 16] = row[cols[j]*16 +: 16];
          b.idx[l*4 +: 4] = 4'(cols[j]);
          b.mask[l]       = 1'b1;
        end
      end
      b.last = (k == nb - 1);
      sb.push_back(b);
    end
  endfunction

  // One clock: sample at negedge, log input accepts into the scoreboard.
  task automatic step(output bit acc, output bit bt, output bit vld, output beat_t got);
    @(negedge clk);
    vld = out_valid;
    bt  = out_valid && out_ready;
    acc = in_valid && in_ready;
    got = '{a: out_a, idx: out_idx, mask: out_mask, last: out_last};
    if (acc) push_model(in_row);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_row = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++;
    if ({out_a, out_idx, out_mask, out_last} !== 85'h0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0", {out_a, out_idx, out_mask, out_last});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_sparse();
    bit acc, bt, vld; beat_t got, exp, b0, b1; int nb;
    in_row = '0;
    in_row[1*16 +: 16]  = 16'h8000;
    in_row[3*16 +: 16]  = 16'h1234;
    in_row[4*16 +: 16]  = 16'h0001;
    in_row[9*16 +: 16]  = 16'hABCD;
    in_row[15*16 +: 16] = 16'h0F0F;
    in_valid = 1'b1; out_ready = 1'b1; nb = 0; b0 = '0; b1 = '0;
    for (int i = 0; i < 30; i++) begin
      step(acc, bt, vld, got);
      if (acc) in_valid = 1'b0;
      if (bt) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL sparse_extra got %h want none", got); end
        else begin
          exp = sb.pop_front();
          if (got !== exp) begin n_err++; $display("FAIL sparse_beat got %h want %h", got, exp); end
        end
        if (nb == 0) b0 = got;
        if (nb == 1) b1 = got;
        nb++;
      end
      if (!in_valid && sb.size() == 0 && nb > 0) break;
    end
    n_cmp++;
    if (nb !== 2) begin n_err++; $display("FAIL sparse_count got %0d want 2", nb); end
    n_cmp++;
    if ({b0.idx, b0.mask, b0.last} !== {16'h9431, 4'b1111, 1'b0}) begin
      n_err++; $display("FAIL sparse_beat1_fields got %h want %h", {b0.idx, b0.mask, b0.last}, {16'h9431, 4'b1111, 1'b0});
    end
    n_cmp++;
    if ({b1.idx, b1.mask, b1.last} !== {16'h000F, 4'b0001, 1'b1}) begin
      n_err++; $display("FAIL sparse_beat2_fields got %h want %h", {b1.idx, b1.mask, b1.last}, {16'h000F, 4'b0001, 1'b1});
    end
  endtask

  task automatic test_zero();
    bit acc, bt, vld; beat_t got, exp; int nb;
    in_row = '0; in_valid = 1'b1; out_ready = 1'b1; nb = 0;
    for (int i = 0; i < 20; i++) begin
      step(acc, bt, vld, got);
      if (acc) in_valid = 1'b0;
      if (bt) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL zero_extra got %h want none", got); end
        else begin
          exp = sb.pop_front();
          if (got !== exp) begin n_err++; $display("FAIL zero_beat got %h want %h", got, exp); end
        end
        n_cmp++;
        if ({got.mask, got.last} !== 5'b00001) begin
          n_err++; $display("FAIL zero_fields got %b want 00001", {got.mask, got.last});
        end
        nb++;
      end
      if (!in_valid && sb.size() == 0 && nb > 0) break;
    end
    n_cmp++;
    if (nb !== 1) begin n_err++; $display("FAIL zero_count got %0d want 1", nb); end
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL zero_idle got %b want 10", {in_ready, out_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dense();
    bit acc, bt, vld; beat_t got, exp; int nb, acc_i, first_i, last_i;
    for (int c = 0; c < 16; c++) in_row[c*16 +: 16] = 16'(16'h0100 + c);
    in_valid = 1'b1; out_ready = 1'b1; nb = 0; acc_i = -1; first_i = -1; last_i = -1;
    for (int i = 0; i < 30; i++) begin
      step(acc, bt, vld, got);
      if (acc) begin in_valid = 1'b0; acc_i = i; end
      if (bt) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL dense_extra got %h want none", got); end
        else begin
          exp = sb.pop_front();
          if (got !== exp) begin n_err++; $display("FAIL dense_beat got %h want %h", got, exp); end
        end
        if (first_i < 0) first_i = i;
        last_i = i;
        nb++;
      end
      if (!in_valid && sb.size() == 0 && nb > 0) break;
    end
    n_cmp++;
    if (nb !== 4) begin n_err++; $display("FAIL dense_count got %0d want 4", nb); end
    n_cmp++;
    if (first_i - acc_i !== 1) begin n_err++; $display("FAIL dense_latency got %0d want 1", first_i - acc_i); end
    n_cmp++;
    if (last_i - first_i !== 3) begin n_err++; $display("FAIL dense_bubbles got span %0d want 3", last_i - first_i); end
  endtask

  task automatic test_stall();
    bit acc, bt, vld, stalled; beat_t got, exp, held; int nb;
    bit pat [0:7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 16; c++) in_row[c*16 +: 16] = 16'(16'hC000 ^ c);
    in_valid = 1'b1; nb = 0; stalled = 1'b0; held = '0;
    for (int i = 0; i < 30; i++) begin
      out_ready = (i < 8) ? pat[i] : 1'b1;
      step(acc, bt, vld, got);
      if (acc) in_valid = 1'b0;
      if (stalled && vld) begin
        n_cmp++;
        if (got !== held) begin n_err++; $display("FAIL stall_hold got %h want %h", got, held); end
      end
      stalled = vld && !bt;
      held    = got;
      if (bt) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL stall_extra got %h want none", got); end
        else begin
          exp = sb.pop_front();
          if (got !== exp) begin n_err++; $display("FAIL stall_beat got %h want %h", got, exp); end
        end
        nb++;
      end
      if (!in_valid && sb.size() == 0 && nb > 0) break;
    end
    n_cmp++;
    if (nb !== 4) begin n_err++; $display("FAIL stall_count got %0d want 4", nb); end
  endtask

  task automatic test_back_to_back();
    bit acc, bt, vld; beat_t got, exp; int nb, sent, first_i, last_i;
    logic [255:0] row_b;
    in_row = '0;
    in_row[0*16 +: 16] = 16'h0011; in_row[2*16 +: 16] = 16'h0022;
    in_row[5*16 +: 16] = 16'h0055; in_row[6*16 +: 16] = 16'h0066;
    in_row[7*16 +: 16] = 16'h0077;
    row_b = '0;
    row_b[10*16 +: 16] = 16'hBEEF;
    in_valid = 1'b1; out_ready = 1'b1; nb = 0; sent = 0; first_i = -1; last_i = -1;
    for (int i = 0; i < 30; i++) begin
      step(acc, bt, vld, got);
      if (acc) begin
        sent++;
        if (sent == 1) in_row = row_b;
        else in_valid = 1'b0;
      end
      if (bt) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL b2b_extra got %h want none", got); end
        else begin
          exp = sb.pop_front();
          if (got !== exp) begin n_err++; $display("FAIL b2b_beat got %h want %h", got, exp); end
        end
        if (first_i < 0) first_i = i;
        last_i = i;
        nb++;
      end
      if (!in_valid && sb.size() == 0 && nb > 0) break;
    end
    n_cmp++;
    if (nb !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", nb); end
    n_cmp++;
    if (last_i - first_i !== 2) begin n_err++; $display("FAIL b2b_bubbles got span %0d want 2", last_i - first_i); end
  endtask

  task automatic test_reset_mid();
    bit acc, bt, vld; beat_t got; int nb;
    in_row = '0;
    for (int c = 0; c < 10; c++) in_row[c*16 +: 16] = 16'(16'h0A00 + c);
    in_valid = 1'b1; out_ready = 1'b1; nb = 0;
    for (int i = 0; i < 20; i++) begin
      step(acc, bt, vld, got);
      if (acc) in_valid = 1'b0;
      if (bt) begin nb++; break; end
    end
    n_cmp++;
    if (nb !== 1) begin n_err++; $display("FAIL rstmid_first_beat got %0d want 1", nb); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_mask, out_last} !== 6'b0) begin
      n_err++; $display("FAIL rstmid_during got %b want 000000", {out_valid, out_mask, out_last});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      step(acc, bt, vld, got);
      n_cmp++;
      if (vld !== 1'b0) begin n_err++; $display("FAIL rstmid_ghost_beat cycle %0d got %b want 0", i, vld); end
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_zero();
    test_dense();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
